multicycle_datapath: RTL

//  Multicycle successor to the single-cycle datapath: one shared memory port with ready handshake, internal FSM

---
 rtl/multicycle_datapath_pkg.sv | 38 +++
 rtl/multicycle_datapath_if.sv | 32 +++
 rtl/multicycle_datapath_ctrl.sv | 105 ++++++++++
 rtl/multicycle_datapath.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multicycle MIPS-subset datapath:
// opcode/funct codes, FSM state encoding and ALU operation encoding.
package multicycle_datapath_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC,
        MEMRD,
        MEMWR,
        WB,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

endpackage

// File: rtl/multicycle_datapath_if.sv
// Unified instruction/data memory port with a req/ready handshake.
// The CPU side is the master; the memory is the slave.
interface multicycle_datapath_if #(
    parameter int N = 32
);

    logic         req;
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         ready;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );

endinterface

// File: rtl/multicycle_datapath_ctrl.sv
// Sequencing FSM: walks each instruction through its states and
// decodes opcode/funct into ALU operation and writeback selects.
module mc_controller
    import multicycle_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       hit,
    output state_t     state,
    output state_t     state_next,
    output alu_op_t    alu_op,
    output logic       use_imm,
    output logic       dst_rd,
    output logic       wb_mem,
    output logic       retire,
    output logic       halted
);

    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_addi;
    logic is_beq;
    logic is_j;
    logic r_ok;

    assign is_r    = opcode == OP_R;
    assign is_lw   = opcode == OP_LW;
    assign is_sw   = opcode == OP_SW;
    assign is_addi = opcode == OP_ADDI;
    assign is_beq  = opcode == OP_BEQ;
    assign is_j    = opcode == OP_J;

    assign use_imm = !is_r;
    assign dst_rd  = is_r;
    assign wb_mem  = is_lw;

    always_comb begin
        alu_op = ALU_ADD;
        r_ok   = 1'b1;
        unique case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: r_ok   = 1'b0;
        endcase
        // Immediate forms (lw/sw/addi) always add.
        if (!is_r) begin
            alu_op = ALU_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
                if (hit) state_next = DECODE;
            end
            DECODE: begin
                unique case (1'b1)
                    is_r:                      state_next = r_ok ? EXEC : HALT;
                    is_lw || is_sw || is_addi: state_next = EXEC;
                    is_beq:                    state_next = BRANCH;
                    is_j:                      state_next = JUMP;
                    default:                   state_next = HALT;
                endcase
            end
            EXEC: begin
                unique case (1'b1)
                    is_lw:   state_next = MEMRD;
                    is_sw:   state_next = MEMWR;
                    default: state_next = WB;
                endcase
            end
            MEMRD: begin
                if (hit) state_next = WB;
            end
            MEMWR: begin
                if (hit) state_next = FETCH;
            end
            WB:      state_next = FETCH;
            BRANCH:  state_next = FETCH;
            JUMP:    state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    assign retire = (state == WB) || (state == BRANCH) || (state == JUMP)
                 || ((state == MEMWR) && hit);
    assign halted = state == HALT;

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: PC, IR, A/B/ALUOut/MDR holding
// registers and a 32-entry register file behind one shared memory port.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_datapath_if.master mem,
    output logic [N-1:0]          pc,
    output logic                  retire,
    output logic                  halted
);

    state_t       state;
    state_t       state_next;
    alu_op_t      alu_op;
    logic         use_imm;
    logic         dst_rd;
    logic         wb_mem;
    logic         hit;
    logic         issue;

    logic [31:0]  ir;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] alu_out;
    logic [N-1:0] mdr;
    logic [N-1:0] rf [32];

    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [4:0]   dst;
    logic [N-1:0] sext;
    logic [N-1:0] src_b;
    logic [N-1:0] alu_y;
    logic [N-1:0] pc_inc;
    logic [N-1:0] pc_next;
    logic [N-1:0] jump_pc;
    logic [N-1:0] wb_data;

    mc_controller u_ctrl (
        .clk        (clk),
        .rst_n      (reset),
        .opcode     (ir[31:26]),
        .funct      (ir[5:0]),
        .hit        (hit),
        .state      (state),
        .state_next (state_next),
        .alu_op     (alu_op),
        .use_imm    (use_imm),
        .dst_rd     (dst_rd),
        .wb_mem     (wb_mem),
        .retire     (retire),
        .halted     (halted)
    );

    assign hit     = mem.req && mem.ready;
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign dst     = dst_rd ? rd : rt;
    assign sext    = {{(N-16){ir[15]}}, ir[15:0]};
    assign src_b   = use_imm ? sext : b;
    assign pc_inc  = pc + N'(4);
    assign jump_pc = {pc[N-1:28], ir[25:0], 2'b00};
    assign wb_data = wb_mem ? mdr : alu_out;

    always_comb begin
        alu_y = '0;
        unique case (alu_op)
            ALU_ADD: alu_y = a + src_b;
            ALU_SUB: alu_y = a - src_b;
            ALU_AND: alu_y = a & src_b;
            ALU_OR:  alu_y = a | src_b;
            ALU_SLT: alu_y = {{(N-1){1'b0}}, $signed(a) < $signed(src_b)};
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        pc_next = pc;
        unique case (state)
            FETCH:   if (hit) pc_next = pc_inc;
            BRANCH:  if (a == b) pc_next = alu_out;
            JUMP:    pc_next = jump_pc;
            default: ;
        endcase
    end

    // Requests are launched on entry to a memory state, so the address
    // is taken from the value the PC / ALU will hold in that state.
    assign issue = !mem.req && ((state_next == FETCH)
                             || (state_next == MEMRD)
                             || (state_next == MEMWR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
        end else if (hit) begin
            mem.req <= 1'b0;
            mem.we  <= 1'b0;
        end else if (issue) begin
            mem.req   <= 1'b1;
            mem.we    <= state_next == MEMWR;
            mem.addr  <= (state_next == FETCH) ? pc_next : alu_y;
            mem.wdata <= b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            pc <= pc_next;
            unique case (state)
                FETCH: begin
                    if (hit) ir <= mem.rdata[31:0];
                end
                DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= pc + (sext << 2);
                end
                EXEC: begin
                    alu_out <= alu_y;
                end
                MEMRD: begin
                    if (hit) mdr <= mem.rdata;
                end
                default: ;
            endcase
        end
    end

    // r0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if ((state == WB) && (dst != 5'd0)) begin
            rf[dst] <= wb_data;
        end
    end

endmodule
